// File: rtl/mac_32.sv
// rtl/mac_32.sv - 32x32 unsigned multiply-accumulate with a 64-bit running sum
module mac_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] accumulator
);

  logic [63:0] acc_q;
  logic [63:0] prod;
  logic [63:0] acc_next;

  // Full-width product: widen both operands so nothing is truncated.
  assign prod = 64'(A) * 64'(B);

  always_comb begin
    acc_next = acc_q + prod;
    if (reset) begin
      acc_next = 64'd0;
    end
  end

  // Output carries the current cycle's product with zero latency.
  assign accumulator = acc_next;

  always_ff @(posedge clk) begin
    acc_q <= acc_next;
  end

endmodule

// File: tb/tb_mac_32.sv
// tb/tb_mac_32.sv - scoreboard testbench for mac_32
module tb_mac_32;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] accumulator;

  logic [63:0] exp_q[$];
  string       name_q[$];
  int          tests_run;
  int          tests_failed;

  mac_32 dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .accumulator(accumulator)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's operands just after the edge and queue its expected output.
  task automatic step(input string nm, input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
    @(posedge clk);
    #1;
    reset = r;
    A     = a;
    B     = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Combinational output is sampled mid-cycle, away from the active edge.
  initial begin
    logic [63:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests_run++;
        if (accumulator !== e) begin
          tests_failed++;
          $display("FAIL %s: accumulator=%h expected=%h", n, accumulator, e);
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    A     = 32'd0;
    B     = 32'd0;

    step("rst0",  1'b1, 32'd0, 32'd0, 64'd0);
    step("rst1",  1'b1, 32'd0, 32'd0, 64'd0);
    step("idle0", 1'b0, 32'd0, 32'd0, 64'd0);
    step("idle1", 1'b0, 32'd0, 32'd0, 64'd0);

    step("acc52", 1'b0, 32'd13, 32'd4, 64'd52);
    step("acc73", 1'b0, 32'd7,  32'd3, 64'd73);
    step("acc91", 1'b0, 32'd3,  32'd6, 64'd91);
    step("pre26158", 1'b0, 32'd26067, 32'd1, 64'd26158);

    step("midrst",  1'b1, 32'd0,     32'd0,     64'd0);
    step("post1",   1'b0, 32'd32091, 32'd11232, 64'd360446112);
    step("post2",   1'b0, 32'd2,     32'd8,     64'd360446128);
    step("zerohold", 1'b0, 32'd0,    32'd12345, 64'd360446128);

    step("rstovr",  1'b1, 32'd10, 32'd5, 64'd0);
    step("afterovr", 1'b0, 32'd10, 32'd5, 64'd50);

    step("rstbig",  1'b1, 32'd0, 32'd0, 64'd0);
    step("big1",    1'b0, 32'd3200967292, 32'd3400113491, 64'h970A7FE5A4897A34);
    step("big2",    1'b0, 32'd1223, 32'd4, 64'h970A7FE5A4898D50);

    step("rstwrap", 1'b1, 32'd0, 32'd0, 64'd0);
    step("wrapmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    step("wrapfill", 1'b0, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFFFFFFFFFF);
    step("wrap",    1'b0, 32'd1, 32'd2, 64'd1);
    step("wrapnext", 1'b0, 32'd3, 32'd3, 64'd10);

    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
